// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the pipelined ALU.
// Op encoding and shift-amount width helper.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    XOR  = 4'd4,
    SLT  = 4'd5,
    SLTU = 4'd6,
    SLL  = 4'd7,
    SRL  = 4'd8,
    SRA  = 4'd9
  } Op;

  localparam int OP_W = 4;

  function automatic int shamt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational WIDTH-bit ALU.
// Ports: op_i/a_i/b_i operation and operands, x_o result.
import alu_pkg::*;

module alu_core #(
  parameter int WIDTH = 8
) (
  input  Op                op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] x_o
);

  localparam int SHAMT_W = shamt_w(WIDTH);

  logic [SHAMT_W-1:0] shamt;
  logic               lt_s;
  logic               lt_u;

  // Only the low shift bits of b count.
  assign shamt = b_i[SHAMT_W-1:0];
  assign lt_s  = $signed(a_i) < $signed(b_i);
  assign lt_u  = a_i < b_i;

  always_comb begin
    x_o = '0;
    case (op_i)
      ADD:     x_o = a_i + b_i;
      SUB:     x_o = a_i - b_i;
      AND:     x_o = a_i & b_i;
      OR:      x_o = a_i | b_i;
      XOR:     x_o = a_i ^ b_i;
      SLT:     x_o = {{(WIDTH-1){1'b0}}, lt_s};
      SLTU:    x_o = {{(WIDTH-1){1'b0}}, lt_u};
      SLL:     x_o = a_i << shamt;
      SRL:     x_o = a_i >> shamt;
      SRA:     x_o = $signed(a_i) >>> shamt;
      default: x_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage ALU with valid/ready on both sides.
// Ports: clk, rst_n; in_valid/in_ready/in_op/in_a/in_b;
//        out_valid/out_ready/out_x/out_zero.
import alu_pkg::*;

module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  Op                in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic             out_zero
);

  typedef struct packed {
    Op                op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } s1_t;

  logic             s1_valid_q, s1_valid_d;
  s1_t              s1_q, s1_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_x_q, s2_x_d;
  logic             s2_zero_q, s2_zero_d;

  logic             s2_ready;
  logic [WIDTH-1:0] core_x;
  logic             core_zero;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op_i (s1_q.op),
    .a_i  (s1_q.a),
    .b_i  (s1_q.b),
    .x_o  (core_x)
  );

  assign core_zero = (core_x == '0);

  // S1 may refill in the same cycle it drains into S2.
  assign s2_ready = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d.op = in_op;
        s1_d.a  = in_a;
        s1_d.b  = in_b;
      end
    end
  end

  // Result regs only load on a real S1 op, so they hold across bubbles.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_x_d     = s2_x_q;
    s2_zero_d  = s2_zero_q;
    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_x_d    = core_x;
        s2_zero_d = core_zero;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '{op: ADD, a: '0, b: '0};
      s2_valid_q <= 1'b0;
      s2_x_q     <= '0;
      s2_zero_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      s2_x_q     <= s2_x_d;
      s2_zero_q  <= s2_zero_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_x     = s2_x_q;
  assign out_zero  = s2_zero_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: random and directed bench for alu_pipe.
// Runs an 8-bit and a 32-bit instance against a queue model.
import alu_pkg::*;

module tb_alu_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       v8, r8, ov8, or8, z8;
  Op          op8;
  logic [7:0] a8, b8, x8;

  logic        v32, r32, ov32, or32, z32;
  Op           op32;
  logic [31:0] a32, b32, x32;

  alu_pipe #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v8),
    .in_ready  (r8),
    .in_op     (op8),
    .in_a      (a8),
    .in_b      (b8),
    .out_valid (ov8),
    .out_ready (or8),
    .out_x     (x8),
    .out_zero  (z8)
  );

  alu_pipe #(.WIDTH(32)) u_dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v32),
    .in_ready  (r32),
    .in_op     (op32),
    .in_a      (a32),
    .in_b      (b32),
    .out_valid (ov32),
    .out_ready (or32),
    .out_x     (x32),
    .out_zero  (z32)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b,
                                        input int w);
    longint m, ua, ub, sa, sb, r;
    logic [63:0] t;
    int sh;
    m  = (longint'(1) << w) - 1;
    ua = longint'(a) & m;
    ub = longint'(b) & m;
    sa = (((ua >> (w - 1)) & 1) != 0) ? ua - (m + 1) : ua;
    sb = (((ub >> (w - 1)) & 1) != 0) ? ub - (m + 1) : ub;
    sh = int'(ub % longint'(w));
    r  = 0;
    case (op)
      ADD:     r = ua + ub;
      SUB:     r = ua - ub;
      AND:     r = ua & ub;
      OR:      r = ua | ub;
      XOR:     r = ua ^ ub;
      SLT:     r = (sa < sb) ? 1 : 0;
      SLTU:    r = (ua < ub) ? 1 : 0;
      SLL:     r = ua << sh;
      SRL:     r = ua >> sh;
      SRA:     r = sa >>> sh;
      default: r = 0;
    endcase
    t = r & m;
    return t[31:0];
  endfunction

  logic [31:0] q8[$];
  logic [31:0] q32[$];
  int pops8 = 0;
  bit saw_stall = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ov8", {31'b0, ov8}, 0);
      chk("rst_x8", {24'b0, x8}, 0);
      chk("rst_z8", {31'b0, z8}, 0);
      q8.delete();
    end else begin
      if (ov8) begin
        if (q8.size() == 0) begin
          chk("stale8", 1, 0);
        end else begin
          chk("x8", {24'b0, x8}, q8[0]);
          chk("z8", {31'b0, z8}, {31'b0, q8[0] == 0});
          if (or8) begin
            void'(q8.pop_front());
            pops8++;
          end
        end
      end
      if (!r8) saw_stall = 1'b1;
      if (v8 && r8)
        q8.push_back(model(op8, {24'b0, a8}, {24'b0, b8}, 8));
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ov32", {31'b0, ov32}, 0);
      q32.delete();
    end else begin
      if (ov32) begin
        if (q32.size() == 0) begin
          chk("stale32", 1, 0);
        end else begin
          chk("x32", x32, q32[0]);
          chk("z32", {31'b0, z32}, {31'b0, q32[0] == 0});
          if (or32) void'(q32.pop_front());
        end
      end
      if (v32 && r32)
        q32.push_back(model(op32, a32, b32, 32));
    end
  end

  task automatic send8(input Op op, input logic [7:0] a, input logic [7:0] b);
    bit acc;
    int k;
    v8 = 1'b1; op8 = op; a8 = a; b8 = b;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      acc = r8;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (k == 200) chk("send8_timeout", 0, 1);
    v8 = 1'b0;
  endtask

  task automatic send32(input Op op, input logic [31:0] a, input logic [31:0] b);
    bit acc;
    int k;
    v32 = 1'b1; op32 = op; a32 = a; b32 = b;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      acc = r32;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (k == 200) chk("send32_timeout", 0, 1);
    v32 = 1'b0;
  endtask

  task automatic dir8(input string tag, input Op op,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp);
    int k;
    send8(op, a, b);
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ov8) break;
    end
    chk({tag, "_x"}, {24'b0, x8}, {24'b0, exp});
    chk({tag, "_z"}, {31'b0, z8}, {31'b0, exp == 8'h00});
    @(posedge clk); #1;
  endtask

  task automatic dir32(input string tag, input Op op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    int k;
    send32(op, a, b);
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ov32) break;
    end
    chk({tag, "_x"}, x32, exp);
    chk({tag, "_z"}, {31'b0, z32}, {31'b0, exp == 32'h0});
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (q8.size() == 0 && !ov8 && q32.size() == 0 && !ov32) break;
    end
    chk({tag, "_drained"}, {31'b0, k < 200}, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0;
    bit done;
    rst_n = 1'b0;
    v8 = 1'b0; op8 = ADD; a8 = '0; b8 = '0; or8 = 1'b1;
    v32 = 1'b0; op32 = ADD; a32 = '0; b32 = '0; or32 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Two register stages: valid at the output after the edge
    // following the accept edge, never right after the accept edge.
    send8(ADD, 8'hF0, 8'h20);
    @(negedge clk);
    chk("lat_s1", {31'b0, ov8}, 0);
    @(negedge clk);
    chk("lat_s2", {31'b0, ov8}, 1);
    chk("add_x", {24'b0, x8}, 32'h10);
    chk("add_z", {31'b0, z8}, 0);
    drain("t1");

    dir8("sub", SUB, 8'h05, 8'h05, 8'h00);
    dir8("slt", SLT, 8'h80, 8'h01, 8'h01);
    dir8("sltu", SLTU, 8'h80, 8'h01, 8'h00);
    dir8("sra", SRA, 8'h80, 8'h0A, 8'hE0);
    dir8("sll", SLL, 8'h01, 8'h07, 8'h80);
    dir8("srl", SRL, 8'h80, 8'h07, 8'h01);
    dir8("undef", Op'(4'd12), 8'h3C, 8'h11, 8'h00);
    drain("t3");

    saw_stall = 1'b0;
    p0 = pops8;
    fork
      begin
        for (int i = 0; i < 16; i++)
          send8(Op'($urandom_range(0, 9)), 8'($urandom), 8'($urandom));
      end
      begin
        repeat (2) @(posedge clk);
        #1 or8 = 1'b0;
        repeat (4) @(posedge clk);
        #1 or8 = 1'b1;
      end
    join
    drain("t4");
    chk("t4_count", pops8 - p0, 16);
    chk("t4_stall", {31'b0, saw_stall}, 1);

    or8 = 1'b0;
    v8 = 1'b1; op8 = ADD; a8 = 8'h01; b8 = 8'h02;
    @(posedge clk); #1;
    op8 = XOR; a8 = 8'h03; b8 = 8'h05;
    @(posedge clk); #1;
    op8 = SUB; a8 = 8'h09; b8 = 8'h01;
    @(negedge clk);
    chk("t5_full_ov", {31'b0, ov8}, 1);
    chk("t5_full_rdy", {31'b0, r8}, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    v8 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    or8 = 1'b1;
    dir8("t5_after", ADD, 8'h07, 8'h09, 8'h10);
    drain("t5");

    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          send8(Op'($urandom_range(0, 11)), 8'($urandom), 8'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          or8 = ($urandom_range(0, 2) != 0);
        end
        or8 = 1'b1;
      end
    join
    drain("rand8");

    dir32("w32_add", ADD, 32'hFFFF_FFFF, 32'h1, 32'h0);
    dir32("w32_sra", SRA, 32'h8000_0000, 32'h21, 32'hC000_0000);
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++)
          send32(Op'($urandom_range(0, 11)), $urandom, $urandom);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          or32 = ($urandom_range(0, 2) != 0);
        end
        or32 = 1'b1;
      end
    join
    drain("rand32");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
